// File: rtl/muldiv_unit_iterative_if.sv
// muldiv_unit_iterative_if: request/result bus of the iterative M-extension unit
//   master drives valid_i/funct3/rs1_data/rs2_data/flush/ready_i,
//   slave drives ready_o/valid_result/result.
interface muldiv_unit_iterative_if #(parameter int DATA_WIDTH = 32);
  logic                  valid_i;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  flush;
  logic                  ready_i;
  logic                  ready_o;
  logic                  valid_result;
  logic [DATA_WIDTH-1:0] result;
  modport master (output valid_i, funct3, rs1_data, rs2_data, flush, ready_i,
                  input  ready_o, valid_result, result);
  modport slave  (input  valid_i, funct3, rs1_data, rs2_data, flush, ready_i,
                  output ready_o, valid_result, result);
endinterface

// File: rtl/muldiv_unit_iterative.sv
// muldiv_unit_iterative: iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU)
//   clock, reset (async, active-high), scan (debug request, no effect on function),
//   bus.slave: valid_i/funct3/rs1_data/rs2_data/flush/ready_i in, ready_o/valid_result/result out.
module muldiv_unit_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_BITS   = 4,
  parameter int CORE       = 0
) (
  input logic                    clock,
  input logic                    reset,
  input logic                    scan,
  muldiv_unit_iterative_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] MUL_N = CW'(W / MUL_BITS);
  localparam logic [CW-1:0] DIV_N = CW'(W);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [W-1:0]        a_q, a_d, quo_q, quo_d, res_q, res_d;
  logic [W:0]          rem_q, rem_d;
  logic [2*W-1:0]      prod_q, prod_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f;
  logic                sa, sb, div0, ovf, neg_in;
  logic [W-1:0]        mag1, mag2, special_res, fix_res, quo_s, rem_s;
  logic [2*W-1:0]      prod_s, mul_next;
  logic [W+MUL_BITS-1:0] partial, mul_sum;
  logic [W:0]          shifted, diff;
  logic [CW-1:0]       last_cnt;
  logic                tie_unused;
  // Debug hooks stay on the port list; remainder bit W is always zero after a step.
  assign tie_unused = scan ^ rem_q[W] ^ (CORE != 0);
  assign f    = bus.funct3;
  // Operand sign only matters for MULH (both), MULHSU (rs1) and DIV/REM (both).
  assign sa   = bus.rs1_data[W-1] & (f == 3'd1 | f == 3'd2 | (f[2] & ~f[0]));
  assign sb   = bus.rs2_data[W-1] & (f == 3'd1 | (f[2] & ~f[0]));
  assign mag1 = sa ? -bus.rs1_data : bus.rs1_data;
  assign mag2 = sb ? -bus.rs2_data : bus.rs2_data;
  assign neg_in = (f[2] & f[1]) ? sa : sa ^ sb;
  assign div0 = bus.rs2_data == '0;
  assign ovf  = f[2] & ~f[0] & (bus.rs1_data == {1'b1, {(W-1){1'b0}}}) & (bus.rs2_data == '1);
  assign special_res = div0 ? (f[1] ? bus.rs1_data : '1) : (f[1] ? '0 : bus.rs1_data);
  // Multiply: add a*digit into the high half, then shift the whole accumulator right.
  assign partial  = {{MUL_BITS{1'b0}}, a_q} * {{W{1'b0}}, prod_q[MUL_BITS-1:0]};
  assign mul_sum  = {{MUL_BITS{1'b0}}, prod_q[2*W-1:W]} + partial;
  assign mul_next = {mul_sum, prod_q[W-1:MUL_BITS]};
  // Restoring divide: a_q holds the divisor, quo_q shifts the dividend out and quotient in.
  assign shifted  = {rem_q[W-1:0], quo_q[W-1]};
  assign diff     = shifted - {1'b0, a_q};
  assign last_cnt = (op_q[2] ? DIV_N : MUL_N) - CW'(1);
  assign prod_s   = neg_q ? -prod_q : prod_q;
  assign quo_s    = neg_q ? -quo_q : quo_q;
  assign rem_s    = neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                            : (op_q == 3'd0 ? prod_s[W-1:0] : prod_s[2*W-1:W]);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (bus.valid_i && !bus.flush) begin
        op_d    = f;
        neg_d   = neg_in;
        a_d     = f[2] ? mag2 : mag1;
        prod_d  = {{W{1'b0}}, mag2};
        quo_d   = mag1;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = (f[2] && (div0 || ovf)) ? DONE : ITER;
        res_d   = (f[2] && (div0 || ovf)) ? special_res : res_q;
      end
      ITER: begin
        cnt_d   = cnt_q + CW'(1);
        prod_d  = op_q[2] ? prod_q : mul_next;
        rem_d   = op_q[2] ? (diff[W] ? shifted : diff) : rem_q;
        quo_d   = op_q[2] ? {quo_q[W-2:0], ~diff[W]} : quo_q;
        state_d = (cnt_q == last_cnt) ? FIX : ITER;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: state_d = bus.ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  assign bus.ready_o      = state_q == IDLE;
  assign bus.valid_result = state_q == DONE;
  assign bus.result       = res_q;
endmodule

// File: tb/tb_muldiv_unit_iterative.sv
// tb_muldiv_unit_iterative: directed self-checking bench for muldiv_unit_iterative
module tb_muldiv_unit_iterative;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  muldiv_unit_iterative_if #(.DATA_WIDTH(32)) bus ();
  muldiv_unit_iterative #(.DATA_WIDTH(32), .MUL_BITS(4), .CORE(0)) dut (
    .clock (clock),
    .reset (reset),
    .scan  (1'b0),
    .bus   (bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.valid_i  = 1'b1;
    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge clock);
    #1;
    bus.valid_i = 1'b0;
  endtask
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input int edges, input logic [31:0] exp);
    start(f, a, b);
    if (edges > 0) begin
      repeat (edges - 1) @(posedge clock);
      #1;
      chk({tag, "_early"}, 32'(bus.valid_result), 32'd0);
      @(posedge clock);
      #1;
    end
    chk({tag, "_valid"}, 32'(bus.valid_result), 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy"}, 32'(bus.ready_o), 32'd0);
    @(posedge clock);
    #1;
    chk({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    chk({tag, "_drop"}, 32'(bus.valid_result), 32'd0);
  endtask
  initial begin
    bus.valid_i = 1'b0; bus.funct3 = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.flush = 1'b0; bus.ready_i = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_result), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run("mul", 3'd0, 32'd4, 32'd7, 9, 32'd28);
    run("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 9, 32'hFFFF_FFF1);
    run("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 9, 32'hFFFF_FFFF);
    run("mulhu", 3'd3, 32'hFFFF_FFFE, 32'd3, 9, 32'h0000_0002);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFF);
    run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run("divu", 3'd5, 32'd100, 32'd7, 33, 32'd14);
    run("remu", 3'd7, 32'd100, 32'd7, 33, 32'd2);
    run("divu_z", 3'd5, 32'd55, 32'd0, 0, 32'hFFFF_FFFF);
    run("div_z", 3'd4, 32'd55, 32'd0, 0, 32'hFFFF_FFFF);
    run("remu_z", 3'd7, 32'd123, 32'd0, 0, 32'd123);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    bus.ready_i = 1'b0;
    start(3'd0, 32'd9, 32'd9);
    repeat (9) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.valid_i = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd1; bus.rs2_data = 32'd1;
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(bus.valid_result), 32'd1);
      chk("hold_res", bus.result, 32'd81);
      chk("hold_busy", 32'(bus.ready_o), 32'd0);
    end
    @(negedge clock);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clock);
    #1;
    chk("hold_release_valid", 32'(bus.valid_result), 32'd0);
    chk("hold_release_ready", 32'(bus.ready_o), 32'd1);
    start(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.ready_o), 32'd1);
    chk("flush_valid", 32'(bus.valid_result), 32'd0);
    chk("flush_res_kept", bus.result, 32'd81);
    repeat (40) @(posedge clock);
    #1;
    chk("flush_no_result", 32'(bus.valid_result), 32'd0);
    @(negedge clock);
    bus.valid_i = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0;
    @(posedge clock);
    #1;
    bus.valid_i = 1'b0; bus.flush = 1'b0;
    chk("flush_idle_reject", 32'(bus.ready_o), 32'd1);
    run("mul_after_flush", 3'd0, 32'd3, 32'd5, 9, 32'd15);
    start(3'd4, 32'd50, 32'd5);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.ready_o), 32'd1);
    chk("arst_valid", 32'(bus.valid_result), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run("mul_after_rst", 3'd0, 32'd6, 32'd7, 9, 32'd42);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
